fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer that owns the program counter and drives ReadAddr of the byte-addressed, big-endian instruction memory (inst_mem, 32 bytes, combinational read).
- Registers each returned 32-bit Instruccion into a fetch output slot with a valid/ready handshake to decode.
- Handles stall/backpressure, branch/jump redirect with flush, and halts at the end of memory.

Parameters:
- MEM_BYTES, 32, size of instruction memory in bytes; must be a multiple of 4.
- RESET_PC, 0, PC value loaded on reset; must be word-aligned and less than MEM_BYTES.
- CNT_W, 16, width of the accepted-instruction counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ReadAddr  output  32  byte address to inst_mem; combinational copy of the internal pc.
- Instruccion  input  32  instruction word returned combinationally by inst_mem for ReadAddr.
- redirect_en  input  1  branch/jump taken; one-cycle pulse.
- redirect_addr  input  32  redirect target byte address; bits [1:0] are ignored.
- if_ready  input  1  decode can accept the output slot.
- if_valid  output  1  output slot holds a valid instruction.
- if_instr  output  32  fetched instruction.
- if_pc  output  32  byte address of if_instr.
- if_pc_plus4  output  32  if_pc + 4.
- halted  output  1  high while in HALT state.
- fetch_count  output  CNT_W  number of accepted handshakes (if_valid && if_ready), saturating.

Behaviour:
- Reset (reset=1 at an edge, in any state, including mid-operation):
  - pc=RESET_PC; state=IDLE.
  - if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0, halted=0, fetch_count=0.
  - Reset overrides every other input.
- States: IDLE, FETCH, HALT.
- IDLE: no capture; unconditionally goes to FETCH on the next edge. redirect_en is ignored in IDLE.
- FETCH:
  - The slot is free when !if_valid || if_ready.
  - On an edge with the slot free and no redirect:
    - if_instr<=Instruccion, if_pc<=pc, if_pc_plus4<=pc+4, if_valid<=1.
    - If pc+4 < MEM_BYTES: pc<=pc+4.
    - Otherwise: pc is held and state<=HALT. The last instruction remains valid in the slot until accepted.
  - On an edge with the slot not free: all registers hold. ReadAddr stays stable.
- Redirect (redirect_en=1 in FETCH or HALT) has priority over capture:
  - if_valid<=0 (flush); no capture that edge.
  - pc<={redirect_addr[31:2],2'b00}.
  - If the aligned target < MEM_BYTES, state<=FETCH; otherwise state<=HALT.
  - Result: the first target instruction appears with if_valid=1 two edges after the redirect edge.
- HALT: halted=1; no captures; pc frozen. Exit only by redirect to an in-range target, or by reset.
- Once if_valid is in HALT, it clears on acceptance: if_valid && if_ready -> if_valid<=0.
- Handshake:
  - A word is accepted on an edge where if_valid && if_ready.
  - A word presented with if_valid && if_ready on the same edge as a redirect counts as accepted; the flush discards nothing already accepted.
  - if_instr, if_pc and if_pc_plus4 must not change while if_valid=1 and if_ready=0, except on a redirect flush.
- Arithmetic:
  - pc+4 wraps modulo 2^32.
  - The range compare (pc+4 < MEM_BYTES, target < MEM_BYTES) uses 33-bit unsigned arithmetic, so a wrapped sum never reads as in-range.
- fetch_count increments by 1 per accepted handshake and saturates at 2^CNT_W-1.
- Throughput: with if_ready held at 1, one instruction per cycle; no bubbles except after reset (IDLE) and after a redirect.

Test Plan:
- Reset then if_ready=1, memory words W0..W7:
  - if_valid rises on the 2nd edge after reset release with if_pc=0, if_instr=W0.
  - if_pc steps 4,8,…,28 on consecutive edges.
  - After W7 is accepted: halted=1, if_valid=0, fetch_count=8.
- Backpressure: if_ready=0 for 3 cycles while if_pc=8 is valid.
  - if_instr/if_pc hold for those 3 cycles.
  - On release the next word is if_pc=12; no instruction is skipped or duplicated.
- Redirect: redirect_en=1 with redirect_addr=0x00000012 while if_pc=4 is valid and if_ready=1.
  - The if_pc=4 word counts as accepted.
  - Next cycle if_valid=0; the following cycle if_pc=0x10.
- Out-of-range redirect: redirect_addr=0x40 in FETCH.
  - Next edge: halted=1, if_valid=0, ReadAddr=0x40 frozen.
  - A later redirect to 0x8 resumes with if_pc=8.
- Reset mid-stream: reset=1 for one edge while if_valid=1 with if_pc=20.
  - All outputs return to 0 and ReadAddr=RESET_PC.
  - Fetching restarts at if_pc=0 two edges later.
- Counter saturation, with CNT_W=3: 10 accepted instructions (using a redirect to 0 to loop) -> fetch_count sticks at 7.

Source files
------------

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer with PC, output slot handshake, redirect and halt
module fetch_ctrl #(
  parameter int MEM_BYTES = 32,
  parameter int RESET_PC  = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      ReadAddr,
  input  logic [31:0]      Instruccion,
  input  logic             redirect_en,
  input  logic [31:0]      redirect_addr,
  input  logic             if_ready,
  output logic             if_valid,
  output logic [31:0]      if_instr,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_pc_plus4,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);
  localparam logic [31:0] PC_INIT   = 32'(RESET_PC);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             valid_q, valid_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      ipc_q, ipc_d;
  logic [31:0]      ipc4_q, ipc4_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [32:0] pc_plus4_33;
  logic [31:0] target;
  logic        target_in_range;
  logic        next_in_range;
  logic        accept;
  logic        slot_free;

  // The two low address bits of a redirect target are dropped on purpose.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, redirect_addr[1:0]};

  // Sums are evaluated one bit wider so a wrapped pc+4 never looks in range.
  assign pc_plus4_33     = {1'b0, pc_q} + 33'd4;
  assign next_in_range   = pc_plus4_33 < MEM_LIMIT;
  assign target          = {redirect_addr[31:2], 2'b00};
  assign target_in_range = {1'b0, target} < MEM_LIMIT;
  assign accept          = valid_q && if_ready;
  assign slot_free       = !valid_q || if_ready;

  assign ReadAddr    = pc_q;
  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc       = ipc_q;
  assign if_pc_plus4 = ipc4_q;
  assign halted      = (state_q == HALT);
  assign fetch_count = cnt_q;

  // Next-state logic: redirect beats capture; capture only into a free slot.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    cnt_d   = cnt_q;

    if (accept && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (redirect_en) begin
          valid_d = 1'b0;
          pc_d    = target;
          state_d = target_in_range ? FETCH : HALT;
        end else if (slot_free) begin
          instr_d = Instruccion;
          ipc_d   = pc_q;
          ipc4_d  = pc_plus4_33[31:0];
          valid_d = 1'b1;
          if (next_in_range) begin
            pc_d = pc_plus4_33[31:0];
          end else begin
            state_d = HALT;
          end
        end
      end
      HALT: begin
        if (redirect_en) begin
          valid_d = 1'b0;
          pc_d    = target;
          state_d = target_in_range ? FETCH : HALT;
        end else if (accept) begin
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset overriding all inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= PC_INIT;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      ipc4_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard testbench for fetch_ctrl
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        if_ready = 1'b0;

  logic [31:0] ReadAddr, Instruccion, if_instr, if_pc, if_pc_plus4;
  logic        if_valid, halted;
  logic [15:0] fetch_count;

  logic [31:0] ReadAddr3, Instruccion3, if_instr3, if_pc3, if_pc_plus43;
  logic        if_valid3, halted3;
  logic [2:0]  fetch_count3;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  // Big-endian memory image: each word encodes its own byte address.
  function automatic logic [31:0] word_at(logic [31:0] a);
    if (a < 32'd32) return {8'hA5, a[7:0], ~a[7:0], 8'h5A};
    return 32'hDEADBEEF;
  endfunction

  assign Instruccion  = word_at(ReadAddr);
  assign Instruccion3 = word_at(ReadAddr3);

  fetch_ctrl #(.MEM_BYTES(32), .RESET_PC(0), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .ReadAddr(ReadAddr), .Instruccion(Instruccion),
    .redirect_en(redirect_en), .redirect_addr(redirect_addr), .if_ready(if_ready),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
    .halted(halted), .fetch_count(fetch_count)
  );

  fetch_ctrl #(.MEM_BYTES(32), .RESET_PC(0), .CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .ReadAddr(ReadAddr3), .Instruccion(Instruccion3),
    .redirect_en(redirect_en), .redirect_addr(redirect_addr), .if_ready(if_ready),
    .if_valid(if_valid3), .if_instr(if_instr3), .if_pc(if_pc3), .if_pc_plus4(if_pc_plus43),
    .halted(halted3), .fetch_count(fetch_count3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    if_ready = 1'b0;
    redirect_en = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Monitor: every accepted handshake must match the next expected pc.
  always @(negedge clk) begin
    if (!reset && if_valid && if_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_accept_pc", if_pc, 32'hFFFFFFFF);
      end else begin
        logic [31:0] p;
        p = exp_q.pop_front();
        chk("sb_pc", if_pc, p);
        chk("sb_instr", if_instr, word_at(p));
        chk("sb_pc_plus4", if_pc_plus4, p + 32'd4);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_pc4", if_pc_plus4, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_count", {16'b0, fetch_count}, 32'd0);
    chk("rst_readaddr", ReadAddr, 32'd0);

    // Straight run to end of memory
    reset = 1'b0;
    if_ready = 1'b1;
    for (int k = 0; k < 8; k++) exp_q.push_back(32'(4 * k));
    tick();
    chk("idle_valid", {31'b0, if_valid}, 32'd0);
    tick();
    chk("first_valid", {31'b0, if_valid}, 32'd1);
    chk("first_pc", if_pc, 32'd0);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("run_pc", if_pc, 32'(4 * k));
    end
    chk("last_halted", {31'b0, halted}, 32'd1);
    chk("last_valid", {31'b0, if_valid}, 32'd1);
    tick();
    chk("end_halted", {31'b0, halted}, 32'd1);
    chk("end_valid", {31'b0, if_valid}, 32'd0);
    chk("end_count", {16'b0, fetch_count}, 32'd8);
    chk("end_count3", {29'b0, fetch_count3}, 32'd7);
    tick();
    chk("halt_readaddr", ReadAddr, 32'd28);

    // Backpressure at if_pc=8, then mid-stream reset at if_pc=20
    do_reset();
    if_ready = 1'b1;
    for (int k = 0; k < 5; k++) exp_q.push_back(32'(4 * k));
    tick();
    tick();
    tick();
    tick();
    chk("bp_pc_before", if_pc, 32'd8);
    if_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_pc", if_pc, 32'd8);
      chk("bp_hold_instr", if_instr, word_at(32'd8));
      chk("bp_hold_valid", {31'b0, if_valid}, 32'd1);
    end
    if_ready = 1'b1;
    tick();
    chk("bp_next_pc", if_pc, 32'd12);
    tick();
    tick();
    chk("mid_pc", if_pc, 32'd20);
    do_reset();
    chk("mid_valid", {31'b0, if_valid}, 32'd0);
    chk("mid_instr", if_instr, 32'd0);
    chk("mid_pc0", if_pc, 32'd0);
    chk("mid_pc4", if_pc_plus4, 32'd0);
    chk("mid_count", {16'b0, fetch_count}, 32'd0);
    chk("mid_readaddr", ReadAddr, 32'd0);

    // Redirect to 0x12 while if_pc=4 is accepted
    if_ready = 1'b1;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd4);
    exp_q.push_back(32'h10);
    exp_q.push_back(32'h14);
    tick();
    tick();
    chk("restart_pc", if_pc, 32'd0);
    chk("restart_valid", {31'b0, if_valid}, 32'd1);
    tick();
    chk("redir_src_pc", if_pc, 32'd4);
    redirect_en = 1'b1;
    redirect_addr = 32'h00000012;
    tick();
    redirect_en = 1'b0;
    chk("redir_flush_valid", {31'b0, if_valid}, 32'd0);
    chk("redir_readaddr", ReadAddr, 32'h10);
    chk("redir_count", {16'b0, fetch_count}, 32'd2);
    tick();
    chk("redir_tgt_pc", if_pc, 32'h10);
    chk("redir_tgt_valid", {31'b0, if_valid}, 32'd1);
    tick();
    chk("redir_tgt2_pc", if_pc, 32'h14);

    // Out-of-range redirect, then recovery to 0x8
    redirect_en = 1'b1;
    redirect_addr = 32'h40;
    tick();
    redirect_en = 1'b0;
    chk("oor_halted", {31'b0, halted}, 32'd1);
    chk("oor_valid", {31'b0, if_valid}, 32'd0);
    chk("oor_readaddr", ReadAddr, 32'h40);
    tick();
    tick();
    chk("oor_frozen", ReadAddr, 32'h40);
    chk("oor_still_valid", {31'b0, if_valid}, 32'd0);
    exp_q.push_back(32'd8);
    redirect_en = 1'b1;
    redirect_addr = 32'h8;
    tick();
    redirect_en = 1'b0;
    chk("rec_halted", {31'b0, halted}, 32'd0);
    chk("rec_valid", {31'b0, if_valid}, 32'd0);
    tick();
    chk("rec_pc", if_pc, 32'd8);
    tick();
    chk("rec_pc2", if_pc, 32'd12);
    chk("rec_count", {16'b0, fetch_count}, 32'd5);
    do_reset();

    // Saturation: full run, redirect to 0 from HALT, three more accepts
    if_ready = 1'b1;
    for (int k = 0; k < 8; k++) exp_q.push_back(32'(4 * k));
    for (int k = 0; k < 3; k++) exp_q.push_back(32'(4 * k));
    for (int k = 0; k < 10; k++) tick();
    chk("sat_halted", {31'b0, halted}, 32'd1);
    redirect_en = 1'b1;
    redirect_addr = 32'd0;
    tick();
    redirect_en = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("sat_pc", if_pc, 32'd12);
    chk("sat_count16", {16'b0, fetch_count}, 32'd11);
    chk("sat_count3", {29'b0, fetch_count3}, 32'd7);
    do_reset();
    tick();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
